mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 7: counter width in bits; legal range is 2..32.
REQ-002 Parameter SATURATE, default 0: 0 wraps at the bounds; 1 holds at the bounds.
REQ-003 Parameter RST_VAL, default 0: value of out after reset; it must be below 2^WIDTH.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  count enable; high allows one step per clock.
REQ-008 up  input  1  direction; 1 counts up, 0 counts down.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 max_val  input  WIDTH  upper bound of the count range, inclusive; the lower bound is 0.
REQ-012 out  output  WIDTH  registered count value.
REQ-013 tc  output  1  registered terminal-count pulse.
REQ-014 zero  output  1  combinational flag; high when out == 0.

Function
REQ-015 Priority at each rising clk edge: rst, then load, then en; when all are low, out holds.
REQ-016 Load: out <= load_val when load_val <= max_val; otherwise out <= max_val.
- Load ignores en and up.
- Load never asserts tc.
REQ-017 Up step, en=1 and up=1:
- out < max_val: out <= out+1.
- out >= max_val: out <= 0 when SATURATE=0, or out <= max_val when SATURATE=1.
REQ-018 Down step, en=1 and up=0:
- 0 < out <= max_val: out <= out-1.
- out == 0: out <= max_val when SATURATE=0, or out holds 0 when SATURATE=1.
- out > max_val: out <= max_val.
REQ-019 A boundary step is an enabled step taken with out >= max_val (up) or out == 0 (down).
REQ-020 tc is high in the cycle after each boundary step, in either SATURATE mode, and low otherwise.
- Consecutive boundary steps give consecutive tc cycles.
REQ-021 Arithmetic is unsigned and WIDTH bits wide; out never leaves the range 0..2^WIDTH-1.
REQ-022 The up and max_val inputs may change on any cycle; the new values take effect at the next edge with no extra latency.
REQ-023 max_val == 0 is legal; out then stays 0, and every enabled step is a boundary step.
REQ-024 Latency: out and tc reflect the inputs sampled at an edge immediately after that edge.

Reset
REQ-025 Asserting rst drives out to RST_VAL and tc to 0 immediately, with no clock edge needed.
REQ-026 While rst is high, the design ignores load and en.
REQ-027 The first step after rst deasserts is taken at the first rising clk edge where rst is low.
REQ-028 Reset asserted mid-count discards any pending tc.
REQ-029 zero follows out during reset.

Verification (WIDTH=7 unless stated)
REQ-030 Async reset:
- Stimulus: count up to 37, then raise rst midway between clock edges.
- Response: out=0 and tc=0 before the next edge; the first edge after release gives out=1 with en=1 and up=1.
REQ-031 Down wrap (SATURATE=0):
- Stimulus: max_val=99, load_val=1, load pulse, then en=1 and up=0.
- Response: out sequence 1, 0, 99, 98; tc high only in the cycle out=99 first appears; zero high only while out=0.
REQ-032 Up saturate (SATURATE=1):
- Stimulus: max_val=127, load 125, then hold en=1 and up=1.
- Response: out 125, 126, 127, 127, 127; tc low, low, high, high.
REQ-033 Load priority and clipping:
- Stimulus: max_val=99, en=1, load=1 with load_val=120.
- Response: out=99 and tc=0; a following up step wraps out to 0 with tc=1.
REQ-034 Runtime bound change:
- Stimulus: out=80 while counting up, max_val changed from 127 to 50.
- Response: next out=0 (SATURATE=0) or 50 (SATURATE=1), with tc=1 in both cases.
- Stimulus: the same change while counting down.
- Response: next out=50, with tc=0.
REQ-035 Hold and direction change:
- Stimulus: en low for 5 cycles, then up toggled on every cycle with en=1.
- Response: out unchanged while en is low, then alternating +1/-1 steps, with no tc away from the bounds.

Source files
------------

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Loadable up/down counter over the range 0..max_val. It either wraps or holds
// at the range bounds, and it gives a one-cycle terminal-count pulse after each
// step that hits a bound.
//
// Parameters
//   WIDTH     counter width in bits (2..32)
//   SATURATE  0: wrap at the bounds, 1: hold at the bounds
//   RST_VAL   value of out while rst is high and after reset is released
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        count enable; one step per clock while high
//   up        direction: 1 counts up, 0 counts down
//   load      synchronous load strobe; wins over en
//   load_val  value to load; clipped to max_val
//   max_val   inclusive upper bound; may change on any cycle
//   out       registered count value
//   tc        registered terminal-count pulse; high in the cycle after a
//             boundary step
//   zero      combinational flag; high when out == 0
// -----------------------------------------------------------------------------
module mod_updown_counter #(
   parameter int unsigned       WIDTH    = 7,
   parameter int unsigned       SATURATE = 0,
   parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             zero
);

   // Kind of update taken at the next edge. Decoding this first keeps the
   // priority (load over en) and the bound cases apart from the arithmetic.
   typedef enum logic [2:0] {
      ST_HOLD,        // no load, no enable
      ST_LOAD,        // load_val, clipped to max_val
      ST_UP,          // out < max_val: increment
      ST_UP_BOUND,    // out >= max_val: wrap to 0 or hold at max_val
      ST_DOWN,        // 0 < out <= max_val: decrement
      ST_DOWN_BOUND,  // out == 0: wrap to max_val or hold at 0
      ST_DOWN_CLIP    // out > max_val after max_val shrank: pull to max_val
   } step_e;

   step_e            step;
   logic             at_top;
   logic             at_bottom;
   logic             above_max;
   logic [WIDTH-1:0] load_clip;
   logic [WIDTH-1:0] out_next;
   logic             tc_next;

   // Compare against the live max_val, so a new bound applies at the very
   // next edge.
   assign at_top    = (out >= max_val);
   assign at_bottom = (out == '0);
   assign above_max = (out >  max_val);
   assign load_clip = (load_val <= max_val) ? load_val : max_val;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      step = ST_HOLD;
      if (load) begin
         step = ST_LOAD;
      end else if (en) begin
         if (up) begin
            step = at_top ? ST_UP_BOUND : ST_UP;
         end else if (at_bottom) begin
            step = ST_DOWN_BOUND;
         end else if (above_max) begin
            step = ST_DOWN_CLIP;
         end else begin
            step = ST_DOWN;
         end
      end
   end

   // Next count and terminal-count pulse. Only the two boundary steps raise
   // tc; they do so in both wrap and saturate modes.
   always_comb begin
      out_next = out;
      tc_next  = 1'b0;
      case (step)
         ST_LOAD: begin
            out_next = load_clip;
         end
         ST_UP: begin
            out_next = out + WIDTH'(1);
         end
         ST_UP_BOUND: begin
            out_next = (SATURATE != 0) ? max_val : '0;
            tc_next  = 1'b1;
         end
         ST_DOWN: begin
            out_next = out - WIDTH'(1);
         end
         ST_DOWN_BOUND: begin
            out_next = (SATURATE != 0) ? '0 : max_val;
            tc_next  = 1'b1;
         end
         ST_DOWN_CLIP: begin
            out_next = max_val;
         end
         default: begin
            out_next = out;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments, so every register
   // samples the values from before the edge, whatever order the blocks run in.
   // Reset is asynchronous: out and tc clear as soon as rst rises, and any
   // pending tc is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= RST_VAL;
         tc  <= 1'b0;
      end else begin
         out <= out_next;
         tc  <= tc_next;
      end
   end

   assign zero = (out == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//
// Testbench for mod_updown_counter. It drives three instances from one shared
// set of inputs:
//   u0: WIDTH=7, wrap mode
//   u1: WIDTH=7, saturate mode
//   u2: WIDTH=4, wrap mode, RST_VAL=9 (gets the low bits of load_val/max_val)
// An arithmetic model of the counting rules follows each instance. It is
// compared with the outputs on every falling edge. Directed scenarios add
// literal expectations at the interesting points, and a constrained random
// phase ends the run.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

   localparam int N = 3;
   localparam int MW  [N] = '{7, 7, 4};
   localparam int MSAT[N] = '{0, 1, 0};
   localparam int MRV [N] = '{0, 0, 9};

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [6:0] load_val;
   logic [6:0] max_val;

   logic [6:0] out0, out1;
   logic [3:0] out2;
   logic       tc0, tc1, tc2;
   logic       zero0, zero1, zero2;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   int m_out[N];
   int m_tc [N];

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(7), .SATURATE(0), .RST_VAL(7'd0)) u0 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .max_val(max_val),
      .out(out0), .tc(tc0), .zero(zero0)
   );

   mod_updown_counter #(.WIDTH(7), .SATURATE(1), .RST_VAL(7'd0)) u1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .max_val(max_val),
      .out(out1), .tc(tc1), .zero(zero1)
   );

   mod_updown_counter #(.WIDTH(4), .SATURATE(0), .RST_VAL(4'd9)) u2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val[3:0]), .max_val(max_val[3:0]),
      .out(out2), .tc(tc2), .zero(zero2)
   );

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int get_out(input int i);
      case (i)
         0:       return int'(out0);
         1:       return int'(out1);
         default: return int'(out2);
      endcase
   endfunction

   function automatic int get_tc(input int i);
      case (i)
         0:       return int'(tc0);
         1:       return int'(tc1);
         default: return int'(tc2);
      endcase
   endfunction

   function automatic int get_zero(input int i);
      case (i)
         0:       return int'(zero0);
         1:       return int'(zero1);
         default: return int'(zero2);
      endcase
   endfunction

   // ------------------------------------------------------------------ model
   // Next count from the counting rules, using plain integer arithmetic on
   // the bounds as seen by instance i.
   function automatic int next_out(input int i, input int cur);
      int mask, lv, mv;
      mask = (1 << MW[i]) - 1;
      lv   = int'(load_val) & mask;
      mv   = int'(max_val) & mask;
      if (load)            return (lv <= mv) ? lv : mv;
      if (!en)             return cur;
      if (up) begin
         if (cur < mv)     return cur + 1;
         return (MSAT[i] != 0) ? mv : 0;
      end
      if (cur == 0)        return (MSAT[i] != 0) ? 0 : mv;
      if (cur > mv)        return mv;
      return cur - 1;
   endfunction

   function automatic int next_tc(input int i, input int cur);
      int mv;
      mv = int'(max_val) & ((1 << MW[i]) - 1);
      if (load || !en) return 0;
      if (up)          return (cur >= mv) ? 1 : 0;
      return (cur == 0) ? 1 : 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            m_out[i] <= MRV[i];
            m_tc[i]  <= 0;
         end else begin
            m_out[i] <= next_out(i, m_out[i]);
            m_tc[i]  <= next_tc(i, m_out[i]);
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < N; i++) begin
            check($sformatf("model_out[u%0d]", i), get_out(i), m_out[i]);
            check($sformatf("model_tc[u%0d]", i), get_tc(i), m_tc[i]);
            check($sformatf("model_zero[u%0d]", i), get_zero(i), (m_out[i] == 0) ? 1 : 0);
         end
      end
   end

   // Hand-computed literal expectation for one instance.
   task automatic lit(input string name, input int i, input int exp_out, input int exp_tc);
      check($sformatf("%s.out[u%0d]", name, i), get_out(i), exp_out);
      check($sformatf("%s.tc[u%0d]", name, i), get_tc(i), exp_tc);
      check($sformatf("%s.zero[u%0d]", name, i), get_zero(i), (exp_out == 0) ? 1 : 0);
   endtask

   // Inputs are set at a falling edge. One rising edge then consumes them,
   // and the task returns at the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      int exp_o[4];
      int exp_t[4];

      rst      = 1'b1;
      en       = 1'b1;
      up       = 1'b1;
      load     = 1'b1;
      load_val = 7'd5;
      max_val  = 7'd127;

      // Reset held: load and en are ignored.
      step();
      cmp_en = 1'b1;
      step();
      lit("reset_hold", 0, 0, 0);
      lit("reset_hold", 1, 0, 0);
      lit("reset_hold", 2, 9, 0);

      // Count up to 37, then reset asynchronously between edges.
      rst  = 1'b0;
      load = 1'b0;
      for (int k = 0; k < 37; k++) step();
      lit("count37", 0, 37, 0);
      lit("count37", 1, 37, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      lit("async_rst", 0, 0, 0);
      lit("async_rst", 1, 0, 0);
      lit("async_rst", 2, 9, 0);
      @(negedge clk);
      step();
      lit("rst_ignores_en", 0, 0, 0);
      rst = 1'b0;
      step();
      lit("first_after_rst", 0, 1, 0);
      lit("first_after_rst", 1, 1, 0);
      lit("first_after_rst", 2, 10, 0);

      // Wrapping down through zero.
      max_val  = 7'd99;
      load_val = 7'd1;
      load     = 1'b1;
      en       = 1'b0;
      step();
      lit("down_load", 0, 1, 0);
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b0;
      step();
      lit("down_0", 0, 0, 0);
      step();
      lit("down_wrap", 0, 99, 1);
      lit("down_sat", 1, 0, 1);
      step();
      lit("down_98", 0, 98, 0);
      lit("down_sat2", 1, 0, 1);

      // A reset between edges drops the pending tc of u1.
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      lit("rst_drops_tc", 1, 0, 0);
      lit("rst_drops_tc", 0, 0, 0);
      #1 rst = 1'b0;
      step();
      lit("after_tc_rst", 0, 0, 0);

      // Saturating at the top.
      max_val  = 7'd127;
      load_val = 7'd125;
      load     = 1'b1;
      step();
      lit("sat_load", 1, 125, 0);
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b1;
      exp_o = '{126, 127, 127, 127};
      exp_t = '{0, 0, 1, 1};
      for (int k = 0; k < 4; k++) begin
         step();
         lit($sformatf("sat_up%0d", k), 1, exp_o[k], exp_t[k]);
      end

      // Load has priority over en and is clipped to max_val.
      max_val  = 7'd99;
      load_val = 7'd120;
      load     = 1'b1;
      step();
      lit("load_clip", 0, 99, 0);
      lit("load_clip", 1, 99, 0);
      load = 1'b0;
      step();
      lit("clip_then_up", 0, 0, 1);
      lit("clip_then_up", 1, 99, 1);

      // max_val shrinks below out while counting up.
      max_val  = 7'd127;
      load_val = 7'd79;
      load     = 1'b1;
      step();
      load = 1'b0;
      step();
      lit("up_to_80", 0, 80, 0);
      lit("up_to_80", 1, 80, 0);
      max_val = 7'd50;
      step();
      lit("shrink_up", 0, 0, 1);
      lit("shrink_up", 1, 50, 1);

      // The same change while counting down.
      max_val  = 7'd127;
      load_val = 7'd81;
      load     = 1'b1;
      step();
      load = 1'b0;
      up   = 1'b0;
      step();
      lit("down_to_80", 0, 80, 0);
      max_val = 7'd50;
      step();
      lit("shrink_down", 0, 50, 0);
      lit("shrink_down", 1, 50, 0);

      // max_val == 0: every enabled step is a boundary step.
      max_val = 7'd0;
      up      = 1'b1;
      step();
      lit("max0_up_a", 0, 0, 1);
      lit("max0_up_a", 1, 0, 1);
      step();
      lit("max0_up_b", 0, 0, 1);
      up = 1'b0;
      step();
      lit("max0_down", 0, 0, 1);
      lit("max0_down", 1, 0, 1);

      // Hold for five cycles, then toggle direction every cycle.
      max_val  = 7'd127;
      load_val = 7'd60;
      load     = 1'b1;
      step();
      load = 1'b0;
      en   = 1'b0;
      up   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         lit($sformatf("hold%0d", k), 0, 60, 0);
      end
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         up = (k % 2 == 0);
         step();
         lit($sformatf("toggle%0d", k), 0, (k % 2 == 0) ? 61 : 60, 0);
         lit($sformatf("toggle%0d", k), 1, (k % 2 == 0) ? 61 : 60, 0);
      end

      // Constrained random phase; small bounds make boundary steps frequent.
      for (int k = 0; k < 400; k++) begin
         en       = ($urandom_range(0, 3) != 0);
         up       = $urandom_range(0, 1) != 0;
         load     = ($urandom_range(0, 9) == 0);
         load_val = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 5))
               0:       max_val = 7'd0;
               1:       max_val = 7'd1;
               2:       max_val = 7'd5;
               3:       max_val = 7'd99;
               4:       max_val = 7'd127;
               default: max_val = 7'($urandom_range(0, 127));
            endcase
         end
         step();
      end

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
